// File: rtl/pixel_filter_pipe.sv
// pixel_filter_pipe: line-selected pixel filter (pass/grey/invert/blur) feeding a
// 12-bit quantiser with optional per-line error-diffusion dither; fixed 3-cycle latency.
module pixel_filter_pipe #(
    parameter int CH_IN  = 6,
    parameter int CH_OUT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  pixel_valid,
    input  logic                  synch_pulse,
    input  logic [3*CH_IN-1:0]    raw_rgb,
    input  logic [1:0]            mode,
    input  logic                  dither_en,
    output logic [3*CH_OUT-1:0]   rgb_out,
    output logic                  out_valid,
    output logic                  out_synch
);
    localparam int D = CH_IN - CH_OUT;
    localparam int W = 3 * CH_IN;
    logic [W-1:0]      d1, d2, d3;
    logic              v1, v2, v3, y1, y2, e1, e2, t1, t2;
    logic [1:0]        m1, m2, line_mode;
    logic              line_dith, start, has_p, has_n;
    logic [D-1:0]      err [3];
    logic [D-1:0]      err_next [3];
    logic [CH_OUT-1:0] q [3];
    logic [CH_IN-1:0]  c [3];
    logic [CH_IN-1:0]  p [3];
    logic [CH_IN-1:0]  n [3];
    logic [CH_IN-1:0]  f [3];
    logic [CH_IN-1:0]  blur [3];
    logic [CH_IN-1:0]  grey;
    logic [CH_IN:0]    sum [3];

    assign start = pixel_valid && synch_pulse;

    // mode/dither are sampled at line start and travel with every pixel of that line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {d1, d2, d3} <= '0;
            {v1, v2, v3, y1, y2, e1, e2, t1, t2} <= '0;
            {m1, m2, line_mode, line_dith} <= '0;
        end else begin
            if (start) begin
                line_mode <= mode;
                line_dith <= dither_en;
            end
            d1 <= raw_rgb;
            v1 <= pixel_valid;
            y1 <= start;
            m1 <= start ? mode : line_mode;
            t1 <= start ? dither_en : line_dith;
            e1 <= enable;
            d2 <= d1;
            v2 <= v1;
            y2 <= y1;
            m2 <= m1;
            t2 <= t1;
            e2 <= e1;
            d3 <= d2;
            v3 <= v2;
        end
    end

    always_comb begin
        has_p = v3 && !y2;
        has_n = v1 && !y1;
        for (int i = 0; i < 3; i++) begin
            c[i] = d2[(2-i)*CH_IN +: CH_IN];
            p[i] = has_p ? d3[(2-i)*CH_IN +: CH_IN] : c[i];
            n[i] = has_n ? d1[(2-i)*CH_IN +: CH_IN] : c[i];
            blur[i] = CH_IN'(((CH_IN+2)'(p[i]) + ((CH_IN+2)'(c[i]) << 1) + (CH_IN+2)'(n[i])) >> 2);
        end
        grey = CH_IN'(((CH_IN+2)'(c[0]) + ((CH_IN+2)'(c[1]) << 1) + (CH_IN+2)'(c[2])) >> 2);
        for (int i = 0; i < 3; i++) begin
            f[i] = m2 == 2'd0 ? c[i] : m2 == 2'd1 ? grey : m2 == 2'd2 ? ~c[i] : blur[i];
            sum[i] = (CH_IN+1)'(f[i]) + (CH_IN+1)'(y2 ? {D{1'b0}} : err[i]);
            q[i] = !t2 ? f[i][CH_IN-1:D] : sum[i][CH_IN] ? {CH_OUT{1'b1}} : sum[i][CH_IN-1:D];
            err_next[i] = (!t2 || sum[i][CH_IN]) ? {D{1'b0}} : sum[i][D-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_out <= '0;
            out_valid <= 1'b0;
            out_synch <= 1'b0;
            err <= '{default: '0};
        end else begin
            out_valid <= v2;
            out_synch <= v2 && y2;
            rgb_out <= (v2 && e2) ? {q[0], q[1], q[2]} : '0;
            if (v2 && e2) err <= err_next;
        end
    end
endmodule

// File: tb/tb_pixel_filter_pipe.sv
// tb_pixel_filter_pipe: scoreboard bench; a line-level reference model predicts every
// output pixel, a negedge monitor checks data, sync, latency and blanking.
module tb_pixel_filter_pipe;
    typedef struct packed { logic v, s; logic [17:0] rgb; logic [1:0] m; logic d, e; } cyc_t;
    typedef struct packed { logic s; logic [11:0] rgb; } exp_t;

    logic clk = 0, reset = 1, enable = 0, pixel_valid = 0, synch_pulse = 0, dither_en = 0;
    logic [17:0] raw_rgb = 0;
    logic [1:0] mode = 0;
    logic [11:0] rgb_out;
    logic out_valid, out_synch;

    cyc_t seg[$];
    exp_t sb[$];
    int due[$];
    int cyc = 0, n_cmp = 0, n_bad = 0;
    int lm = 0;
    bit ld = 0;
    int err [3] = '{0, 0, 0};
    exp_t got_e;
    int got_d;

    pixel_filter_pipe #(.CH_IN(6), .CH_OUT(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pixel_valid(pixel_valid),
        .synch_pulse(synch_pulse), .raw_rgb(raw_rgb), .mode(mode), .dither_en(dither_en),
        .rgb_out(rgb_out), .out_valid(out_valid), .out_synch(out_synch)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(string nm, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h at cycle %0d", nm, got, want, cyc);
        end
    endtask

    function automatic cyc_t px(bit s, int r, int g, int b, int m, bit d, bit e = 1);
        cyc_t c;
        c.v = 1; c.s = s; c.rgb = {6'(r), 6'(g), 6'(b)}; c.m = 2'(m); c.d = d; c.e = e;
        return c;
    endfunction

    function automatic int ch(logic [17:0] d, int i);
        return int'(d[(2-i)*6 +: 6]);
    endfunction

    // reference: filter rules applied to the line as a sequence of samples, then quantise
    task automatic predict();
        int x, pp, nn, f, e, s;
        int o [3];
        bit hp, hn;
        for (int i = 0; i < seg.size(); i++) begin
            if (!seg[i].v) continue;
            if (seg[i].s) begin
                lm = int'(seg[i].m);
                ld = seg[i].d;
            end
            hp = i > 0 && seg[i-1].v && !seg[i].s;
            hn = i + 1 < seg.size() && seg[i+1].v && !seg[i+1].s;
            for (int k = 0; k < 3; k++) begin
                x = ch(seg[i].rgb, k);
                pp = hp ? ch(seg[i-1].rgb, k) : x;
                nn = hn ? ch(seg[i+1].rgb, k) : x;
                case (lm)
                    0: f = x;
                    1: f = (ch(seg[i].rgb, 0) + 2 * ch(seg[i].rgb, 1) + ch(seg[i].rgb, 2)) / 4;
                    2: f = 63 - x;
                    default: f = (pp + 2 * x + nn) / 4;
                endcase
                e = seg[i].s ? 0 : err[k];
                if (!seg[i].e) o[k] = 0;
                else if (!ld) begin
                    o[k] = f / 4;
                    err[k] = 0;
                end else begin
                    s = f + e;
                    o[k] = s > 63 ? 15 : s / 4;
                    err[k] = s > 63 ? 0 : s % 4;
                end
            end
            sb.push_back({seg[i].s, 4'(o[0]), 4'(o[1]), 4'(o[2])});
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1;
        pixel_valid = 0;
        synch_pulse = 0;
        #1;
        check("reset_async", int'({out_valid, out_synch, rgb_out}), 0);
        sb.delete();
        due.delete();
        lm = 0;
        ld = 0;
        err = '{0, 0, 0};
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic run(int cut);
        predict();
        for (int i = 0; i < seg.size() && i < cut; i++) begin
            @(posedge clk); #1;
            {pixel_valid, synch_pulse, raw_rgb, mode, dither_en, enable} = seg[i];
            if (seg[i].v) due.push_back(cyc + 3);
        end
        if (cut < seg.size()) do_reset();
        else repeat (4) begin
            @(posedge clk); #1;
            pixel_valid = 0;
            synch_pulse = 0;
        end
        seg.delete();
    endtask

    always @(negedge clk) if (!reset) begin
        if (out_valid) begin
            if (sb.size() == 0 || due.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output got=%0h want=none at cycle %0d", rgb_out, cyc);
            end else begin
                got_e = sb.pop_front();
                got_d = due.pop_front();
                check("pixel", int'({out_synch, rgb_out}), int'(got_e));
                check("latency", cyc, got_d);
            end
        end else check("blank", int'({out_synch, rgb_out}), 0);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", int'({out_valid, out_synch, rgb_out}), 0);
        reset = 0;
        enable = 1;
        seg.push_back(px(1, 63, 63, 63, 0, 0)); seg.push_back(px(0, 32, 16, 4, 0, 0));
        seg.push_back(px(0, 0, 0, 0, 0, 0));
        run(999);
        seg.push_back(px(1, 40, 20, 8, 1, 0)); seg.push_back(px(1, 0, 63, 32, 2, 0));
        run(999);
        seg.push_back(px(1, 0, 0, 0, 3, 0)); seg.push_back(px(0, 40, 0, 0, 3, 0));
        seg.push_back(px(0, 8, 0, 0, 3, 0));
        run(999);
        seg.push_back(px(1, 0, 0, 0, 3, 0)); seg.push_back(px(0, 40, 0, 0, 3, 0));
        seg.push_back(px(0, 8, 0, 0, 3, 0)); seg.push_back(px(1, 60, 0, 0, 3, 0));
        seg.push_back(px(0, 20, 0, 0, 3, 0)); seg.push_back(px(1, 33, 17, 9, 3, 0));
        run(999);
        for (int i = 0; i < 4; i++) seg.push_back(px(i == 0, 5, 0, 0, 0, 1));
        seg.push_back(px(1, 5, 0, 0, 0, 1)); seg.push_back(px(0, 5, 0, 0, 0, 1));
        seg.push_back(px(0, 5, 0, 0, 0, 1)); seg.push_back(px(0, 63, 0, 0, 0, 1));
        seg.push_back(px(0, 5, 0, 0, 0, 1));
        run(999);
        seg.push_back(px(1, 10, 20, 30, 0, 0)); seg.push_back(px(0, 11, 21, 31, 0, 0));
        seg.push_back(px(0, 12, 22, 32, 2, 0)); seg.push_back(px(0, 13, 23, 33, 2, 0));
        seg.push_back(px(1, 14, 24, 34, 2, 0)); seg.push_back(px(0, 15, 25, 35, 2, 0, 0));
        seg.push_back(px(0, 16, 26, 36, 2, 0, 0)); seg.push_back(px(0, 17, 27, 37, 2, 0));
        run(999);
        seg.push_back(px(1, 40, 40, 40, 3, 1)); seg.push_back(px(0, 50, 10, 30, 3, 1));
        seg.push_back(px(0, 60, 20, 10, 3, 1)); seg.push_back(px(0, 7, 7, 7, 3, 1));
        run(2);
        seg.push_back(px(0, 50, 51, 52, 3, 1)); seg.push_back(px(1, 20, 30, 41, 3, 1));
        seg.push_back(px(0, 21, 31, 42, 3, 1)); seg.push_back(px(0, 22, 35, 43, 3, 1));
        run(999);
        for (int r = 0; r < 30; r++) begin
            int len;
            cyc_t c;
            len = $urandom_range(40, 20);
            for (int j = 0; j < len; j++) begin
                c.v = ($urandom % 8) != 0;
                c.s = (j == 0) || ($urandom % 6) == 0;
                c.rgb = 18'($urandom);
                c.m = 2'($urandom);
                c.d = 1'($urandom);
                c.e = ($urandom % 10) != 0;
                seg.push_back(c);
            end
            run((r % 7 == 6) ? int'($urandom_range(len - 1, 1)) : 999);
        end
        repeat (5) @(posedge clk);
        #1;
        check("leftover", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
